// File: rtl/io_patgen_pkg.sv
// io_patgen shared definitions: register map, FSM states, pattern entry layout.
package io_patgen_pkg;

  localparam logic [11:0] OFS_CTRL  = 12'h000;
  localparam logic [11:0] OFS_STAT  = 12'h004;
  localparam logic [11:0] OFS_PU    = 12'h008;
  localparam logic [11:0] OFS_CAP   = 12'h00C;
  localparam logic [11:0] OFS_ENTRY = 12'h040;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_LOOP  = 2;
  localparam int CTRL_INTEN = 3;
  localparam int CTRL_LAST  = 8;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_IDX  = 8;

  localparam int CAP_IDX  = 8;
  localparam int CAP_FLAG = 31;

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [15:0] hold;
    logic [7:0]  oe;
    logic [7:0]  po;
  } entry_t;

endpackage

// File: rtl/io_patgen_ram.sv
// Pattern entry store: flop array, one write port, separate fetch and APB read ports.
module io_patgen_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = $clog2(DEPTH)
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          we,
  input  logic [DW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [DW-1:0] faddr,
  output logic [31:0]   fdata,
  input  logic [DW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [DEPTH-1:0][31:0] mem;

  always_ff @(posedge pclk) begin
    if (reset)   mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign fdata = mem[faddr];
  assign rdata = mem[raddr];

endmodule

// File: rtl/io_patgen.sv
// Pin pattern generator on an IO mux alternate-function slot, APB configured.
// Optional pin capture on the last cycle of each entry: IO_PATGEN_CAPTURE_EN.
module io_patgen
  import io_patgen_pkg::*;
#(
  parameter int NIO   = 8,
  parameter int DEPTH = 16,
  parameter int DW    = $clog2(DEPTH)
) (
  input  logic           pclk,
  input  logic           reset,
  input  logic           sfrlock,
  input  logic           psel,
  input  logic           penable,
  input  logic           pwrite,
  input  logic [11:0]    paddr,
  input  logic [31:0]    pwdata,
  output logic [31:0]    prdata,
  output logic           pready,
  output logic           pslverr,
  output logic [NIO-1:0] po,
  output logic [NIO-1:0] oe,
  output logic [NIO-1:0] pu,
  input  logic [NIO-1:0] pi,
  output logic           busy,
  output logic           irq
);

  localparam logic [9:0] EBASE = OFS_ENTRY[11:2];

  logic           wr, sel_ctrl, sel_stat, sel_pu, sel_cap, sel_entry;
  logic [9:0]     word, eoff;
  logic           start_wr, stop_wr, w1c_done;
  logic           ctrl_loop, ctrl_inten;
  logic [DW-1:0]  ctrl_last, last_eff;
  logic [NIO-1:0] pu_q, po_q, oe_q;
  state_e         state;
  logic [DW-1:0]  idx, faddr;
  logic [15:0]    cnt;
  logic           done;
  logic [31:0]    fdata, rdata, cap_word;
  entry_t         fent;

  assign wr        = psel & penable & pwrite & ~sfrlock;
  assign word      = paddr[11:2];
  assign eoff      = word - EBASE;
  assign sel_ctrl  = (word == OFS_CTRL[11:2]);
  assign sel_stat  = (word == OFS_STAT[11:2]);
  assign sel_pu    = (word == OFS_PU[11:2]);
  assign sel_cap   = (word == OFS_CAP[11:2]);
  assign sel_entry = (word >= EBASE) && (eoff < 10'(DEPTH));

  assign start_wr = wr & sel_ctrl & pwdata[CTRL_START];
  assign stop_wr  = wr & sel_ctrl & pwdata[CTRL_STOP];
  assign w1c_done = wr & sel_stat & pwdata[STAT_DONE];

  assign last_eff = (32'(ctrl_last) > DEPTH - 1) ? DW'(DEPTH - 1) : ctrl_last;
  // Next entry to load: 0 on start or wrap, otherwise the successor.
  assign faddr    = (state == RUN && idx < last_eff) ? idx + 1'b1 : '0;
  assign fent     = entry_t'(fdata);

  io_patgen_ram #(.DEPTH(DEPTH), .DW(DW)) u_ram (
    .pclk  (pclk),
    .reset (reset),
    .we    (wr & sel_entry),
    .waddr (eoff[DW-1:0]),
    .wdata (pwdata),
    .faddr (faddr),
    .fdata (fdata),
    .raddr (eoff[DW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge pclk) begin
    if (reset) begin
      ctrl_loop  <= 1'b0;
      ctrl_inten <= 1'b0;
      ctrl_last  <= '0;
      pu_q       <= '1;
    end else if (wr) begin
      if (sel_ctrl) begin
        ctrl_loop  <= pwdata[CTRL_LOOP];
        ctrl_inten <= pwdata[CTRL_INTEN];
        ctrl_last  <= pwdata[CTRL_LAST +: DW];
      end
      if (sel_pu) pu_q <= pwdata[NIO-1:0];
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      po_q  <= '0;
      oe_q  <= '0;
      done  <= 1'b0;
    end else begin
      // A completion in the same cycle overrides the clear below.
      if (w1c_done) done <= 1'b0;
      case (state)
        IDLE: if (start_wr && !stop_wr) begin
          state <= RUN;
          idx   <= '0;
          cnt   <= fent.hold;
          po_q  <= fent.po[NIO-1:0];
          oe_q  <= fent.oe[NIO-1:0];
        end
        RUN: begin
          if (stop_wr) begin
            state <= IDLE;
            po_q  <= '0;
            oe_q  <= '0;
          end else if (cnt != 16'd0) begin
            cnt <= cnt - 16'd1;
          end else if (idx < last_eff || ctrl_loop) begin
            idx  <= faddr;
            cnt  <= fent.hold;
            po_q <= fent.po[NIO-1:0];
            oe_q <= fent.oe[NIO-1:0];
          end else begin
            state <= IDLE;
            done  <= 1'b1;
            po_q  <= '0;
            oe_q  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IO_PATGEN_CAPTURE_EN
  logic [NIO-1:0] cap_pi;
  logic [DW-1:0]  cap_idx;
  logic           cap_flag;

  always_ff @(posedge pclk) begin
    if (reset) begin
      cap_pi   <= '0;
      cap_idx  <= '0;
      cap_flag <= 1'b0;
    end else if (state == RUN && cnt == 16'd0) begin
      cap_pi   <= pi;
      cap_idx  <= idx;
      cap_flag <= 1'b1;
    end else if (state == IDLE && start_wr && !stop_wr) begin
      cap_flag <= 1'b0;
    end
  end

  always_comb begin
    cap_word               = '0;
    cap_word[NIO-1:0]      = cap_pi;
    cap_word[CAP_IDX +: DW] = cap_idx;
    cap_word[CAP_FLAG]     = cap_flag;
  end
`else
  logic unused_pi;
  assign unused_pi = ^pi;
  assign cap_word  = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{paddr[1:0], eoff};

  always_comb begin
    prdata = '0;
    if (sel_ctrl) begin
      prdata[CTRL_LOOP]        = ctrl_loop;
      prdata[CTRL_INTEN]       = ctrl_inten;
      prdata[CTRL_LAST +: DW]  = ctrl_last;
    end else if (sel_stat) begin
      prdata[STAT_BUSY]        = (state == RUN);
      prdata[STAT_DONE]        = done;
      prdata[STAT_IDX +: DW]   = idx;
    end else if (sel_pu) begin
      prdata[NIO-1:0]          = pu_q;
    end else if (sel_cap) begin
      prdata                   = cap_word;
    end else if (sel_entry) begin
      prdata                   = rdata;
    end
  end

  assign pready  = 1'b1;
  assign pslverr = 1'b0;
  assign po      = po_q;
  assign oe      = oe_q;
  assign pu      = pu_q;
  assign busy    = (state == RUN);
  assign irq     = done & ctrl_inten;

endmodule

// File: tb/tb_io_patgen.sv
// Self-checking bench for io_patgen: register table, directed corner cases, random runs vs model.
module tb_io_patgen;

  logic        pclk = 1'b0;
  logic        reset, sfrlock, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, busy, irq;
  logic [7:0]  po, oe, pu, pi;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] sh_hold [16];
  logic [7:0]  sh_oe   [16];
  logic [7:0]  sh_po   [16];

  io_patgen dut (
    .pclk(pclk), .reset(reset), .sfrlock(sfrlock),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .po(po), .oe(oe), .pu(pu), .pi(pi), .busy(busy), .irq(irq)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    tick();
    penable = 1'b1;
    #1 d = prdata;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic set_entry(input int k, input logic [15:0] h, input logic [7:0] e, input logic [7:0] p);
    apb_wr(12'(32'h40 + 4 * k), {h, e, p});
    sh_hold[k] = h; sh_oe[k] = e; sh_po[k] = p;
  endtask

  // Expected pin stream is the flat list of entries, each repeated hold+1 times.
  task automatic run_seq(input logic lp, input logic ie, input int lst, input int stop_after);
    logic [15:0] q[$];
    logic [31:0] d, cw;
    apb_wr(12'h004, 32'h2);
    for (int e = 0; e <= lst; e++)
      for (int r = 0; r <= int'(sh_hold[e]); r++) q.push_back({sh_oe[e], sh_po[e]});
    cw = {16'd0, 4'd0, 4'(lst), 4'd0, ie, lp, 2'b00};
    apb_wr(12'h000, cw | 32'h1);
    if (stop_after < 0) begin
      for (int k = 0; k < q.size(); k++) begin
        chk($sformatf("pins[%0d]", k), {16'd0, oe, po}, {16'd0, q[k]});
        tick();
      end
      chk("end_pins", {16'd0, oe, po}, 32'd0);
      chk("end_busy", {31'd0, busy}, 32'd0);
      apb_rd(12'h004, d);
      chk("end_done", {31'd0, d[1]}, 32'd1);
      chk("end_irq", {31'd0, irq}, {31'd0, ie});
    end else begin
      for (int k = 0; k < stop_after; k++) begin
        chk($sformatf("loop_pins[%0d]", k), {16'd0, oe, po}, {16'd0, q[k % q.size()]});
        tick();
      end
      apb_wr(12'h000, cw | 32'h2);
      chk("stop_pins", {16'd0, oe, po}, 32'd0);
      chk("stop_busy", {31'd0, busy}, 32'd0);
      apb_rd(12'h004, d);
      chk("stop_done", {31'd0, d[1]}, 32'd0);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  initial begin
    vec_t        tbl[12];
    logic [31:0] d;
    int          cnt;

    tbl[0]  = '{1'b0, 12'h000, 32'h0,        32'h0,        "ctrl_rst"};
    tbl[1]  = '{1'b0, 12'h004, 32'h0,        32'h0,        "stat_rst"};
    tbl[2]  = '{1'b0, 12'h008, 32'h0,        32'hFF,       "pu_rst"};
    tbl[3]  = '{1'b0, 12'h040, 32'h0,        32'h0,        "entry0_rst"};
    tbl[4]  = '{1'b0, 12'h010, 32'h0,        32'h0,        "unmapped_lo"};
    tbl[5]  = '{1'b0, 12'h00C, 32'h0,        32'h0,        "cap_rst"};
    tbl[6]  = '{1'b1, 12'h008, 32'h0000FF3C, 32'h3C,       "pu_wr"};
    tbl[7]  = '{1'b1, 12'h054, 32'hDEADBEEF, 32'hDEADBEEF, "entry5_wr"};
    tbl[8]  = '{1'b1, 12'h000, 32'h00000F0C, 32'h00000F0C, "ctrl_wr"};
    tbl[9]  = '{1'b1, 12'h000, 32'h0,        32'h0,        "ctrl_clr"};
    tbl[10] = '{1'b1, 12'h008, 32'hFF,       32'hFF,       "pu_restore"};
    tbl[11] = '{1'b1, 12'h080, 32'h1234,     32'h0,        "unmapped_hi"};

    reset = 1'b1; sfrlock = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pi = '0;
    for (int k = 0; k < 16; k++) begin sh_hold[k] = '0; sh_oe[k] = '0; sh_po[k] = '0; end
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pins", {16'd0, oe, po}, 32'd0);
    chk("rst_pu", {24'd0, pu}, 32'hFF);
    chk("pready", {30'd0, pready, pslverr}, 32'h2);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) apb_wr(tbl[i].addr, tbl[i].wdata);
      apb_rd(tbl[i].addr, d);
      chk(tbl[i].name, d, tbl[i].exp);
      if (tbl[i].addr == 12'h008) chk({tbl[i].name, "_pin"}, {24'd0, pu}, tbl[i].exp);
    end
    set_entry(5, 16'h0, 8'h0, 8'h0);

    // One-shot timing, then inten enabled afterwards raises irq from sticky done
    set_entry(0, 16'd2, 8'hFF, 8'hA5);
    set_entry(1, 16'd0, 8'h0F, 8'h3C);
    run_seq(1'b0, 1'b0, 1, -1);
    apb_wr(12'h000, 32'h00000108);
    chk("irq_late_inten", {31'd0, irq}, 32'd1);
    run_seq(1'b0, 1'b1, 1, -1);
    apb_wr(12'h004, 32'h2);
    chk("irq_w1c", {31'd0, irq}, 32'd0);

    // Loop three passes then stop
    run_seq(1'b1, 1'b0, 1, 12);

    // Lock: start and PU writes ignored
    sfrlock = 1'b1;
    apb_wr(12'h000, 32'h101);
    chk("lock_busy", {31'd0, busy}, 32'd0);
    apb_wr(12'h008, 32'h0);
    chk("lock_pu", {24'd0, pu}, 32'hFF);
    sfrlock = 1'b0;

    // Start+stop in one write stays idle
    apb_wr(12'h000, 32'h103);
    chk("startstop_busy", {31'd0, busy}, 32'd0);

    // Second start during a run is ignored
    apb_wr(12'h000, 32'h101);
    apb_wr(12'h000, 32'h101);
    chk("restart_a5", {24'd0, po}, 32'hA5);
    tick();
    chk("restart_3c", {24'd0, po}, 32'h3C);
    tick();
    chk("restart_idle", {31'd0, busy}, 32'd0);

    // Done set on the same edge as a W1C: set wins
    apb_wr(12'h004, 32'h2);
    apb_wr(12'h000, 32'h101);
    tick(); tick();
    apb_wr(12'h004, 32'h2);
    apb_rd(12'h004, d);
    chk("done_vs_w1c", {30'd0, d[1:0]}, 32'h2);

    // Capture: pi during entry 1
    pi = 8'h5A;
    run_seq(1'b0, 1'b0, 1, -1);
    apb_rd(12'h00C, d);
`ifdef IO_PATGEN_CAPTURE_EN
    chk("cap", d, 32'h8000015A);
`else
    chk("cap", d, 32'h0);
`endif
    pi = 8'h00;

    // Every entry held one cycle, idx walks 0..15
    for (int e = 0; e < 16; e++) set_entry(e, 16'd0, 8'(~(e * 17)), 8'(e * 16 + e));
    run_seq(1'b0, 1'b1, 15, -1);

    // Random one-shot runs
    for (int r = 0; r < 6; r++) begin
      int lst;
      lst = $urandom_range(0, 7);
      for (int e = 0; e <= lst; e++)
        set_entry(e, 16'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      run_seq(1'b0, 1'($urandom), lst, -1);
    end
    // Random looping runs with a random stop point
    for (int r = 0; r < 3; r++) begin
      int lst;
      lst = $urandom_range(0, 3);
      for (int e = 0; e <= lst; e++)
        set_entry(e, 16'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      run_seq(1'b1, 1'($urandom), lst, $urandom_range(5, 40));
    end

    // Mid-run reset
    apb_wr(12'h008, 32'h0F);
    set_entry(0, 16'd2, 8'hFF, 8'hA5);
    set_entry(1, 16'd0, 8'h0F, 8'h3C);
    apb_wr(12'h000, 32'h105);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_pins", {16'd0, oe, po}, 32'd0);
    chk("mrst_pu", {24'd0, pu}, 32'hFF);
    apb_rd(12'h000, d);
    chk("mrst_ctrl", d, 32'h0);
    apb_rd(12'h044, d);
    chk("mrst_entry1", d, 32'h0);

    // Maximum hold: single entry held 65536 cycles
    set_entry(0, 16'hFFFF, 8'hFF, 8'hA5);
    apb_wr(12'h000, 32'h001);
    cnt = 0;
    while (busy && cnt < 70000) begin
      if (po == 8'hA5 && oe == 8'hFF) cnt++;
      tick();
    end
    chk("hold_max", 32'(cnt), 32'd65536);
    chk("hold_max_pins", {16'd0, oe, po}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
